// File: rtl/mult_pkg.sv
// Encodings shared by the multi-cycle multiply controller and hilo_unit.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_t;

   localparam logic SEL_LO = 1'b0;
   localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/hilo_unit_if.sv
// Controller-side bus of hilo_unit: MULT issue, MTHI/MTLO writes, MFHI/MFLO reads, stall/busy.
interface hilo_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  mult_req;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic                  mthi;
   logic                  mtlo;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_req;
   logic                  rd_sel;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  stall;
   logic                  busy;

   modport master (
      output mult_req, op_a, op_b, mthi, mtlo, wr_data, rd_req, rd_sel,
      input  rd_data, stall, busy
   );

   modport slave (
      input  mult_req, op_a, op_b, mthi, mtlo, wr_data, rd_req, rd_sel,
      output rd_data, stall, busy
   );
endinterface

// File: rtl/hilo_regs.sv
// HI/LO architectural registers: MT vs product write muxing and the read mux.
// With HILO_BYPASS_EN the caller may raise bypass to forward the arriving product.
module hilo_regs
   import mult_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    hi_we,
   input  logic                    lo_we,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    prod_we,
   input  logic [2*DATA_WIDTH-1:0] prod,
   input  logic                    rd_sel,
   input  logic                    bypass,
   output logic [DATA_WIDTH-1:0]   rd_data
);

   logic [DATA_WIDTH-1:0] hi_r;
   logic [DATA_WIDTH-1:0] lo_r;
   logic [DATA_WIDTH-1:0] rd_data_s;

   // HI/LO state; a product write always replaces both halves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= {DATA_WIDTH{1'b0}};
         lo_r <= {DATA_WIDTH{1'b0}};
      end else if (prod_we) begin
         hi_r <= prod[2*DATA_WIDTH-1:DATA_WIDTH];
         lo_r <= prod[DATA_WIDTH-1:0];
      end else begin
         if (hi_we) begin
            hi_r <= wr_data;
         end
         if (lo_we) begin
            lo_r <= wr_data;
         end
      end
   end

   // Read mux: forwarded product half or the stored register
   always_comb begin
      rd_data_s = {DATA_WIDTH{1'b0}};
      if (bypass) begin
         if (rd_sel == SEL_HI) begin
            rd_data_s = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         end else begin
            rd_data_s = prod[DATA_WIDTH-1:0];
         end
      end else if (rd_sel == SEL_HI) begin
         rd_data_s = hi_r;
      end else begin
         rd_data_s = lo_r;
      end
   end

   assign rd_data = rd_data_s;

endmodule

// File: rtl/hilo_unit.sv
// Issue stage around the sequential multiplier: operand latch, launch FSM, HI/LO and hazard stall.
// Optional HILO_BYPASS_EN forwards the product to a read arriving on the mult_valid cycle.
module hilo_unit
   import mult_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hilo_unit_if.slave              ctl,
   output logic                    mult_start,
   output logic [DATA_WIDTH-1:0]   mult_op1,
   output logic [DATA_WIDTH-1:0]   mult_op2,
   input  logic [2*DATA_WIDTH-1:0] mult_result,
   input  logic                    mult_valid
);

   state_t                state_r;
   logic                  busy_r;
   logic                  start_r;
   logic [DATA_WIDTH-1:0] op1_r;
   logic [DATA_WIDTH-1:0] op2_r;

   logic idle_s;
   logic prod_we_s;
   logic hi_we_s;
   logic lo_we_s;
   logic bypass_s;
   logic stall_s;

   // Hazard decode: MT writes only land while idle, everything else waits for the multiplier
   always_comb begin
      idle_s    = (state_r == IDLE);
      prod_we_s = (state_r == WAIT) && mult_valid;
      hi_we_s   = idle_s && ctl.mthi;
      lo_we_s   = idle_s && ctl.mtlo;
`ifdef HILO_BYPASS_EN
      bypass_s  = prod_we_s && ctl.rd_req && !ctl.mult_req && !ctl.mthi && !ctl.mtlo;
`else
      bypass_s  = 1'b0;
`endif
      if (busy_r && (ctl.mult_req || ctl.mthi || ctl.mtlo || ctl.rd_req) && !bypass_s) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
   end

   // Launch FSM with registered busy/start and operand latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         start_r <= 1'b0;
         op1_r   <= {DATA_WIDTH{1'b0}};
         op2_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (ctl.mult_req) begin
                  op1_r   <= ctl.op_a;
                  op2_r   <= ctl.op_b;
                  state_r <= LAUNCH;
                  busy_r  <= 1'b1;
                  start_r <= 1'b1;
               end
            end
            LAUNCH: begin
               state_r <= WAIT;
               start_r <= 1'b0;
            end
            WAIT: begin
               if (mult_valid) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               start_r <= 1'b0;
            end
         endcase
      end
   end

   hilo_regs #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regs (
      .clk     (clk),
      .rst_n   (rst_n),
      .hi_we   (hi_we_s),
      .lo_we   (lo_we_s),
      .wr_data (ctl.wr_data),
      .prod_we (prod_we_s),
      .prod    (mult_result),
      .rd_sel  (ctl.rd_sel),
      .bypass  (bypass_s),
      .rd_data (ctl.rd_data)
   );

   assign ctl.stall  = stall_s;
   assign ctl.busy   = busy_r;
   assign mult_start = start_r;
   assign mult_op1   = op1_r;
   assign mult_op2   = op2_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: behavioural multiplier plus a product scoreboard.
module tb_hilo_unit;

   localparam int DW  = 32;
   localparam int LAT = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   hilo_unit_if #(.DATA_WIDTH(DW)) bus ();

   logic              mult_start;
   logic [DW-1:0]     mult_op1;
   logic [DW-1:0]     mult_op2;
   logic [2*DW-1:0]   mult_result = '0;
   logic              mult_valid  = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [2*DW-1:0] sb[$];
   logic [DW-1:0]   exp_hi = '0;
   logic [DW-1:0]   exp_lo = '0;

   int              cnt      = 0;
   int              inj_cnt  = 0;
   int              inj_seen = 0;
   logic [2*DW-1:0] inj_res  = '0;
   logic [2*DW-1:0] prod     = '0;

   hilo_unit #(.DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ctl         (bus),
      .mult_start  (mult_start),
      .mult_op1    (mult_op1),
      .mult_op2    (mult_op2),
      .mult_result (mult_result),
      .mult_valid  (mult_valid)
   );

   always #10 clk = ~clk;

   // Behavioural multiplier: valid pulse LAT negedges after it sees start; can inject stray pulses
   always @(negedge clk) begin
      if (!rst_n) begin
         cnt        = 0;
         mult_valid = 1'b0;
         inj_seen   = inj_cnt;
      end else begin
         mult_valid = 1'b0;
         if (inj_cnt != inj_seen) begin
            inj_seen    = inj_cnt;
            mult_valid  = 1'b1;
            mult_result = inj_res;
         end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               mult_valid  = 1'b1;
               mult_result = prod;
            end
         end
         if (mult_start) begin
            cnt  = LAT;
            prod = 64'(mult_op1) * 64'(mult_op2);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
      bus.mult_req = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      tick();
      bus.mult_req = 1'b0;
      sb.push_back(64'(a) * 64'(b));
   endtask

   task automatic read_hilo(output logic [DW-1:0] h, output logic [DW-1:0] l, output logic st);
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'b1;
      #1;
      h  = bus.rd_data;
      st = bus.stall;
      bus.rd_sel = 1'b0;
      #1;
      l  = bus.rd_data;
      st = st | bus.stall;
      bus.rd_req = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mult_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", mult_start); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
      checks++; if (mult_op1 !== 32'h0 || mult_op2 !== 32'h0) begin errors++; $display("FAIL rst_ops got %h %h exp 0", mult_op1, mult_op2); end
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL rst_hi got %h exp 0", bus.rd_data); end
      bus.rd_sel = 1'b0;
      #1;
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL rst_lo got %h exp 0", bus.rd_data); end
      bus.rd_req = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_mult();
      logic [2*DW-1:0] e;
      logic [DW-1:0] h, l;
      logic st;
      bit ok;
      bus.mult_req = 1'b1;
      bus.op_a = 32'h0001_0000;
      bus.op_b = 32'h0001_0000;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mult_accept_stall got %b exp 0", bus.stall); end
      tick();
      bus.mult_req = 1'b0;
      sb.push_back(64'(32'h0001_0000) * 64'(32'h0001_0000));
      checks++; if (mult_start !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL mult_launch got start %b busy %b exp 1 1", mult_start, bus.busy); end
      checks++; if (mult_op1 !== 32'h0001_0000 || mult_op2 !== 32'h0001_0000) begin errors++; $display("FAIL mult_ops got %h %h exp 00010000", mult_op1, mult_op2); end
      tick();
      checks++; if (mult_start !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL mult_pulse got start %b busy %b exp 0 1", mult_start, bus.busy); end
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL mult_valid_timeout got 0 exp 1"); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_drop got %b exp 0", bus.busy); end
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo || st !== 1'b0) begin errors++; $display("FAIL mult_hilo got %h %h st %b exp %h %h st 0", h, l, st, exp_hi, exp_lo); end
   endtask

   task automatic test_rd_stall();
      logic [2*DW-1:0] e;
      int n;
      issue(32'h8000_0003, 32'h0000_0010);
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.stall !== 1'b1) break;
         n++;
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_stall_busy got %b exp 1", bus.busy); end
         tick();
      end
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
`ifdef HILO_BYPASS_EN
      checks++; if (n != 3) begin errors++; $display("FAIL rd_stall_cycles got %0d exp 3", n); end
`else
      checks++; if (n != 4) begin errors++; $display("FAIL rd_stall_cycles got %0d exp 4", n); end
`endif
      checks++; if (bus.stall !== 1'b0 || bus.rd_data !== exp_hi) begin errors++; $display("FAIL rd_stall_data got %h st %b exp %h st 0", bus.rd_data, bus.stall, exp_hi); end
      bus.rd_req = 1'b0;
      tick();
   endtask

   task automatic test_mt();
      logic [2*DW-1:0] e;
      logic [DW-1:0] h, l;
      logic st;
      bit ok;
      bus.mthi    = 1'b1;
      bus.wr_data = 32'hDEAD_BEEF;
      bus.rd_req  = 1'b1;
      bus.rd_sel  = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b0 || bus.rd_data !== exp_hi) begin errors++; $display("FAIL mt_read_old got %h st %b exp %h st 0", bus.rd_data, bus.stall, exp_hi); end
      tick();
      bus.mthi   = 1'b0;
      bus.rd_req = 1'b0;
      exp_hi = 32'hDEAD_BEEF;
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL mthi got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
      bus.mthi    = 1'b1;
      bus.mtlo    = 1'b1;
      bus.wr_data = 32'h0BAD_F00D;
      tick();
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      exp_hi = 32'h0BAD_F00D;
      exp_lo = 32'h0BAD_F00D;
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL mt_both got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
      bus.mtlo    = 1'b1;
      bus.wr_data = 32'h1111_2222;
      issue(32'h2, 32'h3);
      bus.mtlo = 1'b0;
      exp_lo = 32'h1111_2222;
      bus.rd_sel = 1'b0;
      #1;
      checks++; if (bus.rd_data !== exp_lo) begin errors++; $display("FAIL mt_with_mult got %h exp %h", bus.rd_data, exp_lo); end
      bus.mthi    = 1'b1;
      bus.wr_data = 32'h1234_5678;
      bus.rd_sel  = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b1 || bus.rd_data !== exp_hi) begin errors++; $display("FAIL mt_busy_stall got %h st %b exp %h st 1", bus.rd_data, bus.stall, exp_hi); end
      tick();
      checks++; if (bus.rd_data !== exp_hi) begin errors++; $display("FAIL mt_busy_hold got %h exp %h", bus.rd_data, exp_hi); end
      bus.mthi = 1'b0;
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL mt_valid_timeout got 0 exp 1"); end
      tick();
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL mt_product_overwrite got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
   endtask

   task automatic test_req_hold();
      logic [2*DW-1:0] e;
      logic [DW-1:0] h, l;
      logic st;
      bit ok;
      issue(32'h11, 32'h22);
      bus.mult_req = 1'b1;
      bus.op_a = 32'h33;
      bus.op_b = 32'h44;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.stall !== 1'b1) break;
         checks++; if (mult_op1 !== 32'h11 || mult_op2 !== 32'h22) begin errors++; $display("FAIL hold_ops got %h %h exp 11 22", mult_op1, mult_op2); end
         tick();
      end
      checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL hold_release got st %b busy %b exp 0 0", bus.stall, bus.busy); end
      tick();
      bus.mult_req = 1'b0;
      sb.push_back(64'(32'h33) * 64'(32'h44));
      checks++; if (mult_op1 !== 32'h33 || mult_op2 !== 32'h44 || mult_start !== 1'b1) begin errors++; $display("FAIL hold_accept got %h %h start %b exp 33 44 1", mult_op1, mult_op2, mult_start); end
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      bus.rd_sel = 1'b0;
      #1;
      checks++; if (bus.rd_data !== exp_lo) begin errors++; $display("FAIL hold_first_lo got %h exp %h", bus.rd_data, exp_lo); end
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_valid_timeout got 0 exp 1"); end
      tick();
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL hold_second got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
   endtask

   task automatic test_bypass();
      logic [2*DW-1:0] e;
      logic [DW-1:0] h, l;
      logic st;
      bit ok;
      issue(32'h5, 32'h1);
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL byp_valid_timeout got 0 exp 1"); end
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'b0;
      #1;
`ifdef HILO_BYPASS_EN
      checks++; if (bus.stall !== 1'b0 || bus.rd_data !== 32'h5) begin errors++; $display("FAIL byp_forward got %h st %b exp 5 st 0", bus.rd_data, bus.stall); end
      bus.rd_req = 1'b0;
      tick();
`else
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL byp_stall got %b exp 1", bus.stall); end
      tick();
      checks++; if (bus.stall !== 1'b0 || bus.rd_data !== 32'h5) begin errors++; $display("FAIL byp_next got %h st %b exp 5 st 0", bus.rd_data, bus.stall); end
      bus.rd_req = 1'b0;
`endif
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL byp_hilo got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
   endtask

   task automatic test_ignore_valid();
      logic [DW-1:0] h, l;
      logic st;
      inj_res = 64'hFFFF_FFFF_FFFF_FFFF;
      inj_cnt++;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stray_busy got %b exp 0", bus.busy); end
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL stray_valid got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
   endtask

   task automatic test_reset_mid();
      logic [2*DW-1:0] e;
      logic [DW-1:0] h, l;
      logic st;
      bit ok;
      bus.mthi    = 1'b1;
      bus.wr_data = 32'hCAFE_F00D;
      tick();
      bus.mthi = 1'b0;
      issue(32'h7, 32'h9);
      tick();
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || mult_start !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL midrst_ctl got busy %b start %b st %b exp 0 0 0", bus.busy, mult_start, bus.stall); end
      checks++; if (mult_op1 !== 32'h0 || mult_op2 !== 32'h0) begin errors++; $display("FAIL midrst_ops got %h %h exp 0", mult_op1, mult_op2); end
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h exp 0", bus.rd_data); end
      bus.rd_sel = 1'b0;
      #1;
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h exp 0", bus.rd_data); end
      bus.rd_req = 1'b0;
      void'(sb.pop_back());
      exp_hi = '0;
      exp_lo = '0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (bus.busy !== 1'b0 || mult_start !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy %b start %b exp 0 0", bus.busy, mult_start); end
      end
      issue(32'h6, 32'h7);
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_valid_timeout got 0 exp 1"); end
      tick();
      e = sb.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      read_hilo(h, l, st);
      checks++; if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL midrst_after got %h %h exp %h %h", h, l, exp_hi, exp_lo); end
   endtask

   initial begin
      bus.mult_req = 1'b0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      bus.mthi     = 1'b0;
      bus.mtlo     = 1'b0;
      bus.wr_data  = '0;
      bus.rd_req   = 1'b0;
      bus.rd_sel   = 1'b0;
      test_reset();
      test_mult();
      test_rd_stall();
      test_mt();
      test_req_hold();
      test_bypass();
      test_ignore_valid();
      test_reset_mid();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule
